// File: rtl/mem_accumulator.sv
// mem_accumulator: reads N_WORDS consecutive words starting at START_ADDR from a memory with a
// fixed read latency, sums them without loss, and writes the DATA_W-bit result to RES_ADDR.
// Build option: define ACCUM_SAT_EN to write all-ones on overflow instead of the wrapped sum.
// The overflow flag behaves the same in both builds.
module mem_accumulator #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned N_WORDS    = 31,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned RES_ADDR   = 31,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] address,
  output logic              rden,
  output logic              wren,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              ready,
  output logic              overflow
);

  localparam int unsigned CNT_W = $clog2(N_WORDS + 1);
  // Wide enough that N_WORDS maximal words never lose a carry.
  localparam int unsigned ACC_W = DATA_W + CNT_W;

  localparam logic [CNT_W-1:0]  NWordsC    = CNT_W'(N_WORDS);
  localparam logic [ADDR_W-1:0] StartAddrC = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] ResAddrC   = ADDR_W'(RES_ADDR);
  localparam logic [2:0]        LatLastC   = 3'(RD_LAT);

  localparam logic [63:0] AddrSpace = 64'd1 << ADDR_W;
  localparam logic [63:0] RangeEnd  = 64'(START_ADDR) + 64'(N_WORDS);

  // Elaboration-time parameter sanity checks.
  if (N_WORDS < 1 || 64'(N_WORDS) >= AddrSpace) begin : g_chk_nwords
    $error("mem_accumulator: N_WORDS must be 1..2^ADDR_W-1");
  end
  if (RangeEnd > AddrSpace) begin : g_chk_range
    $error("mem_accumulator: START_ADDR+N_WORDS exceeds the address space");
  end
  if (64'(RES_ADDR) >= AddrSpace) begin : g_chk_res
    $error("mem_accumulator: RES_ADDR outside the address space");
  end
  if (RES_ADDR >= START_ADDR && 64'(RES_ADDR) < RangeEnd) begin : g_chk_overlap
    $error("mem_accumulator: RES_ADDR lies inside the summed range");
  end
  if (RD_LAT < 1 || RD_LAT > 7) begin : g_chk_lat
    $error("mem_accumulator: RD_LAT must be 1..7");
  end

  typedef enum logic [2:0] {
    StIdle,
    StSetAddr,
    StRead,
    StAcc,
    StWSetup,
    StWrite,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          lat_q, lat_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic                rden_q, rden_d;
  logic                wren_q, wren_d;
  logic [DATA_W-1:0]   dataout_q, dataout_d;
  logic                ready_q, ready_d;
  logic                overflow_q, overflow_d;

  // Sequencing, read-latency count, word capture, accumulation and the overflow flag.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    word_d     = word_q;
    acc_d      = acc_q;
    overflow_d = overflow_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StSetAddr;
          cnt_d      = '0;
          acc_d      = '0;
          overflow_d = 1'b0;
        end
      end
      StSetAddr: begin
        lat_d   = '0;
        state_d = StRead;
      end
      StRead: begin
        // Data issued with the first rden cycle arrives on the last one.
        if (lat_q == LatLastC) begin
          word_d  = datain;
          state_d = StAcc;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      StAcc: begin
        acc_d = acc_q + ACC_W'(word_q);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == NWordsC) begin
          state_d    = StWSetup;
          overflow_d = |acc_d[ACC_W-1:DATA_W];
        end else begin
          state_d = StSetAddr;
        end
      end
      StWSetup: state_d = StWrite;
      StWrite:  state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Registered memory-side outputs, aligned with the state they belong to.
  always_comb begin
    address_d = address_q;
    dataout_d = dataout_q;
    rden_d    = (state_d == StRead);
    wren_d    = (state_d == StWrite);
    ready_d   = (state_d == StDone);
    if (state_d == StSetAddr) begin
      address_d = StartAddrC + ADDR_W'(cnt_d);
    end
    if (state_d == StWSetup) begin
      address_d = ResAddrC;
`ifdef ACCUM_SAT_EN
      dataout_d = overflow_d ? {DATA_W{1'b1}} : acc_d[DATA_W-1:0];
`else
      dataout_d = acc_d[DATA_W-1:0];
`endif
    end
  end

  // State register; reset aborts any run and clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      lat_q      <= '0;
      word_q     <= '0;
      acc_q      <= '0;
      address_q  <= '0;
      rden_q     <= 1'b0;
      wren_q     <= 1'b0;
      dataout_q  <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      word_q     <= word_d;
      acc_q      <= acc_d;
      address_q  <= address_d;
      rden_q     <= rden_d;
      wren_q     <= wren_d;
      dataout_q  <= dataout_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
    end
  end

  assign address  = address_q;
  assign rden     = rden_q;
  assign wren     = wren_q;
  assign dataout  = dataout_q;
  assign ready    = ready_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mem_accumulator.sv
// Bench for mem_accumulator: default instance (id 0) and a small 8-bit instance (id 1), each
// attached to a latency-accurate memory model. Expected results come from plain summation.
module tb_mem_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start0, start1;
  logic [4:0]  address0;
  logic [3:0]  address1;
  logic        rden0, rden1, wren0, wren1, ready0, ready1, overflow0, overflow1;
  logic [15:0] datain0, dataout0;
  logic [7:0]  datain1, dataout1;

  int n_cmp;
  int n_fail;

  mem_accumulator u_dut0 (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start0),
    .address  (address0),
    .rden     (rden0),
    .wren     (wren0),
    .datain   (datain0),
    .dataout  (dataout0),
    .ready    (ready0),
    .overflow (overflow0)
  );

  mem_accumulator #(
    .DATA_W     (8),
    .ADDR_W     (4),
    .N_WORDS    (4),
    .START_ADDR (2),
    .RES_ADDR   (0),
    .RD_LAT     (4)
  ) u_dut1 (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start1),
    .address  (address1),
    .rden     (rden1),
    .wren     (wren1),
    .datain   (datain1),
    .dataout  (dataout1),
    .ready    (ready1),
    .overflow (overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: read data appears RD_LAT clocks after a rden cycle; bubbles carry junk.
  logic [15:0] mem0  [32];
  logic [7:0]  mem1  [16];
  logic [15:0] pipe0 [2];
  logic [7:0]  pipe1 [4];
  int          wr_cnt  [2];
  int          wr_addr [2];
  int          wr_data [2];

  always @(posedge clk) begin
    pipe0[0] <= rden0 ? mem0[address0] : 16'hDEAD;
    pipe0[1] <= pipe0[0];
    pipe1[0] <= rden1 ? mem1[address1] : 8'hA5;
    for (int i = 1; i < 4; i++) pipe1[i] <= pipe1[i-1];
    if (wren0) begin
      wr_cnt[0]  <= wr_cnt[0] + 1;
      wr_addr[0] <= int'(address0);
      wr_data[0] <= int'(dataout0);
    end
    if (wren1) begin
      wr_cnt[1]  <= wr_cnt[1] + 1;
      wr_addr[1] <= int'(address1);
      wr_data[1] <= int'(dataout1);
    end
  end

  assign datain0 = pipe0[1];
  assign datain1 = pipe1[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus protocol monitor.
  int mon_rlen [2];
  int mon_wlen [2];
  bit mon_prd  [2];
  bit mon_pwr  [2];
  int mon_padr [2];

  task automatic mon_step(input int id, input bit rd, input bit wr, input int addr, input int lat);
    if (!rst_n) begin
      mon_rlen[id] = 0;
      mon_wlen[id] = 0;
      mon_prd[id]  = 1'b0;
      mon_pwr[id]  = 1'b0;
      mon_padr[id] = addr;
      return;
    end
    if (rd && mon_prd[id]) check("addr_stable_rden", 64'(addr), 64'(mon_padr[id]));
    if (rd) mon_rlen[id]++;
    else if (mon_prd[id]) begin
      check("rden_len", 64'(mon_rlen[id]), 64'(lat + 1));
      mon_rlen[id] = 0;
    end
    if (wr) begin
      check(mon_pwr[id] ? "addr_stable_wren" : "addr_setup_wren", 64'(addr), 64'(mon_padr[id]));
      mon_wlen[id]++;
    end else if (mon_pwr[id]) begin
      check("wren_len", 64'(mon_wlen[id]), 64'd1);
      mon_wlen[id] = 0;
    end
    mon_prd[id]  = rd;
    mon_pwr[id]  = wr;
    mon_padr[id] = addr;
  endtask

  always @(negedge clk) begin
    mon_step(0, rden0, wren0, int'(address0), 2);
    mon_step(1, rden1, wren1, int'(address1), 4);
  end

  task automatic set_start(input int id, input logic v);
    if (id == 0) start0 = v;
    else start1 = v;
  endtask

  function automatic logic get_ready(input int id);
    return (id == 0) ? ready0 : ready1;
  endfunction

  function automatic logic [63:0] get_dout(input int id);
    return (id == 0) ? 64'(dataout0) : 64'(dataout1);
  endfunction

  function automatic logic get_ovf(input int id);
    return (id == 0) ? overflow0 : overflow1;
  endfunction

  // One complete run against the summation model.
  task automatic run(input int id, output logic [63:0] dout, output logic ovf);
    logic [63:0] sum, mask, exp_d;
    logic        exp_o;
    int          n, st, lat, res, k, wc;
    if (id == 0) begin
      n = 31; st = 0; lat = 2; res = 31; mask = 64'hFFFF;
    end else begin
      n = 4; st = 2; lat = 4; res = 0; mask = 64'hFF;
    end
    sum = '0;
    for (int i = 0; i < n; i++) begin
      sum += (id == 0) ? 64'(mem0[st+i]) : 64'(mem1[st+i]);
    end
    exp_o = (sum > mask);
    exp_d = sum & mask;
`ifdef ACCUM_SAT_EN
    if (exp_o) exp_d = mask;
`endif
    wc = wr_cnt[id];
    @(negedge clk);
    set_start(id, 1'b1);
    @(posedge clk);
    #1;
    set_start(id, 1'b0);
    check("ovf_clear_on_accept", 64'(get_ovf(id)), 64'd0);
    k = 1;
    while (!get_ready(id) && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("run_len", 64'(k), 64'(n * (lat + 3) + 3));
    @(posedge clk);
    #1;
    check("ready_width", 64'(get_ready(id)), 64'd0);
    dout = get_dout(id);
    ovf  = get_ovf(id);
    check("result", dout, exp_d);
    check("overflow", 64'(ovf), 64'(exp_o));
    check("write_count", 64'(wr_cnt[id] - wc), 64'd1);
    check("write_addr", 64'(wr_addr[id]), 64'(res));
    check("write_data", 64'(wr_data[id]), exp_d);
  endtask

  typedef struct {
    string       name;
    logic [15:0] base;
    logic [15:0] step;
    logic [15:0] exp_wrap;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d, exp;
    logic        o;
    int          t, prev, np, wc;

    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int i = 0; i < 32; i++) mem0[i] = '0;
    for (int i = 0; i < 16; i++) mem1[i] = '0;

    vecs[0] = '{"incr",      16'h0001, 16'h0001, 16'h01F0, 1'b0};
    vecs[1] = '{"zero",      16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[2] = '{"f800",      16'h0800, 16'h0000, 16'hF800, 1'b0};
    vecs[3] = '{"just_fits", 16'h0842, 16'h0000, 16'hFFFE, 1'b0};
    vecs[4] = '{"all_ones",  16'hFFFF, 16'h0000, 16'hFFE1, 1'b1};
    vecs[5] = '{"just_over", 16'h0843, 16'h0000, 16'h001D, 1'b1};

    // Reset values.
    #1;
    check("rst_address", 64'(address0), 64'd0);
    check("rst_rden", 64'(rden0), 64'd0);
    check("rst_wren", 64'(wren0), 64'd0);
    check("rst_dataout", 64'(dataout0), 64'd0);
    check("rst_ready", 64'(ready0), 64'd0);
    check("rst_overflow", 64'(overflow0), 64'd0);
    check("rst_dut1_address", 64'(address1), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table on the default instance.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 32; i++) mem0[i] = vecs[v].base + vecs[v].step * 16'(i);
      run(0, d, o);
      exp = 64'(vecs[v].exp_wrap);
`ifdef ACCUM_SAT_EN
      if (vecs[v].exp_ovf) exp = 64'hFFFF;
`endif
      check({"vec_", vecs[v].name, "_dout"}, d, exp);
      check({"vec_", vecs[v].name, "_ovf"}, 64'(o), 64'(vecs[v].exp_ovf));
    end

    // Overflow and result held while idle.
    repeat (10) @(posedge clk);
    #1;
    check("ovf_hold", 64'(overflow0), 64'd1);
    check("dout_hold", 64'(dataout0), exp);

    // Small instance: four 0x80 words overflow 8 bits.
    for (int i = 0; i < 16; i++) mem1[i] = 8'($urandom);
    for (int i = 2; i < 6; i++) mem1[i] = 8'h80;
    run(1, d, o);
`ifdef ACCUM_SAT_EN
    check("small_dout", d, 64'hFF);
`else
    check("small_dout", d, 64'h00);
`endif
    check("small_ovf", 64'(o), 64'd1);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) mem1[i] = 8'($urandom);
      if (r == 0) for (int i = 2; i < 6; i++) mem1[i] = mem1[i] & 8'h3F;
      run(1, d, o);
    end

    // Randomised runs on the default instance.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++) begin
        mem0[i] = 16'($urandom);
        if (r[0]) mem0[i] = mem0[i] & 16'h07FF;
      end
      run(0, d, o);
    end

    // Start held high: back-to-back runs, one idle cycle between them.
    for (int i = 0; i < 32; i++) mem0[i] = 16'(i + 1);
    wc = wr_cnt[0];
    @(negedge clk);
    start0 = 1'b1;
    t = 0;
    np = 0;
    prev = 0;
    while (np < 3 && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
      if (ready0) begin
        if (np == 0) check("held_first", 64'(t), 64'd158);
        else check("held_gap", 64'(t - prev), 64'd159);
        prev = t;
        np++;
        if (np == 3) start0 = 1'b0;
      end
    end
    check("held_pulses", 64'(np), 64'd3);
    np = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (ready0) np++;
    end
    check("held_no_extra_run", 64'(np), 64'd0);
    check("held_writes", 64'(wr_cnt[0] - wc), 64'd3);
    check("held_dout", 64'(dataout0), 64'h01F0);

    // Reset in the middle of word 10.
    for (int i = 0; i < 32; i++) mem0[i] = 16'hFFFF;
    run(0, d, o);
    for (int i = 0; i < 32; i++) mem0[i] = 16'(i + 1);
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (52) @(posedge clk);
    #1;
    check("pre_reset_rden", 64'(rden0), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_rden", 64'(rden0), 64'd0);
    check("abort_wren", 64'(wren0), 64'd0);
    check("abort_address", 64'(address0), 64'd0);
    check("abort_dataout", 64'(dataout0), 64'd0);
    check("abort_overflow", 64'(overflow0), 64'd0);
    wc = wr_cnt[0];
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    np = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (ready0) np++;
    end
    check("abort_no_ready", 64'(np), 64'd0);
    check("abort_no_write", 64'(wr_cnt[0] - wc), 64'd0);
    run(0, d, o);
    check("after_reset_dout", d, 64'h01F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
